cpu_ctrl: RTL and testbench
===========================

CPU_CTRL -- requirements
Module: cpu_ctrl

Interface
REQ-001 SHALL have parameter TMO_MAX, default 15, meaning max cycles to wait for any stage done before error (range 1..15).
REQ-002 SHALL have port clk  input  1  rising-edge system clock.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  begin execution from IDLE.
REQ-005 SHALL have port ir  input  16  instruction word; opcode = ir[15:12].
REQ-006 SHALL have port fetch_done  input  1  instruction fetch complete, ir valid.
REQ-007 SHALL have port exec_done  input  1  ALU operand capture plus ALU result complete.
REQ-008 SHALL have port mem_done  input  1  memory access complete.
REQ-009 SHALL have port stall  input  1  freeze controller in current state.
REQ-010 SHALL have port en_fetch  output  1  one-cycle fetch enable.
REQ-011 SHALL have port en_exec  output  1  one-cycle enable to ALU operand mux (en_in).
REQ-012 SHALL have port en_mem  output  1  one-cycle memory enable.
REQ-013 SHALL have port en_wb  output  1  one-cycle register write-back enable.
REQ-014 SHALL have port alu_in_sel  output  1  0 = sign-extended offset, 1 = rs operand.
REQ-015 SHALL have port mem_we  output  1  memory write strobe qualifier, valid with en_mem.
REQ-016 SHALL have port busy  output  1  high in any state except IDLE and HALT.
REQ-017 SHALL have port halted  output  1  high in HALT.
REQ-018 SHALL have port err  output  2  error code: 0 none, 1 illegal opcode, 2 timeout.
REQ-019 SHALL have port instr_cnt  output  16  retired-instruction count.

Function
REQ-020 SHALL implement states IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, all registered.
REQ-021 IDLE: start=1 -> FETCH; otherwise stay.
REQ-022 Enable pulses SHALL assert for exactly one cycle, in the first cycle after entering FETCH/EXEC/MEM/WB; never two enables in the same cycle.
REQ-023 FETCH waits for fetch_done -> DECODE; DECODE lasts exactly 1 cycle.
REQ-024 DECODE by opcode: 0x0 NOP -> FETCH; 0x1 ADD -> EXEC with alu_in_sel=1; 0x2 ADDI -> EXEC with alu_in_sel=0; 0x3 LOAD and 0x4 STORE -> EXEC with alu_in_sel=0 (address = rd + offset); 0xF HALT -> HALT; all others -> HALT with err=1.
REQ-025 alu_in_sel SHALL be registered in DECODE and held until next DECODE.
REQ-026 EXEC on exec_done: ADD/ADDI -> WB; LOAD/STORE -> MEM.
REQ-027 MEM on mem_done: LOAD -> WB; STORE -> FETCH. mem_we=1 for STORE, 0 otherwise.
REQ-028 WB lasts 1 cycle (en_wb pulse) -> FETCH.
REQ-029 instr_cnt SHALL increment by 1 on each retirement: leaving DECODE for NOP, leaving WB, leaving MEM for STORE, entering HALT via opcode 0xF. Wraps 0xFFFF -> 0x0000; illegal opcodes not counted.
REQ-030 Wait-state timeout: a 4-bit counter cleared on state entry increments each non-stalled cycle in FETCH/EXEC/MEM while done=0; when it reaches TMO_MAX and done is still 0 -> HALT with err=2.
REQ-031 A done arriving in the same cycle the counter reaches TMO_MAX SHALL win (normal transition, no error).
REQ-032 stall=1 SHALL hold state, counter, and instr_cnt, and suppress enable pulses; a pending pulse issues in the first cycle after stall drops. Done inputs are ignored while stalled.
REQ-033 HALT is terminal until reset; start is ignored there.
REQ-034 Done inputs in states that do not wait on them SHALL be ignored.

Reset
REQ-035 rst=1 SHALL asynchronously force IDLE; all enables, alu_in_sel, mem_we, busy, halted = 0; err = 0; instr_cnt = 0; timeout counter = 0.
REQ-036 Reset asserted mid-instruction SHALL abort with no further enable pulses; the first post-reset activity requires start.

Verification
REQ-037 ADDI (ir=0x2005), fetch_done at cycle 2, exec_done 1 cycle after en_exec -> en_exec pulse, alu_in_sel=0, en_wb pulse, instr_cnt=1, back in FETCH with en_fetch pulse.
REQ-038 LOAD then STORE, mem_done 3 cycles after en_mem -> LOAD: en_mem, mem_we=0, en_wb; STORE: mem_we=1, no en_wb; instr_cnt=2.
REQ-039 exec_done never asserted, TMO_MAX=15 -> HALT 15 cycles after EXEC entry, err=2, halted=1, busy=0; exec_done coincident with count 15 -> WB, err=0.
REQ-040 ir=0x7000 -> HALT, err=1, instr_cnt unchanged; ir=0xF000 -> HALT, err=0, instr_cnt+1.
REQ-041 stall held 5 cycles on EXEC entry -> no en_exec during stall; single pulse on first unstalled cycle; timeout does not advance.
REQ-042 rst pulsed during MEM -> immediate IDLE, all outputs 0, instr_cnt=0; no en_wb follows.

Source files
------------

// File: rtl/cpu_ctrl.sv
// cpu_ctrl: multi-cycle instruction sequencer.
// Walks FETCH -> DECODE -> EXEC -> MEM -> WB for a small ISA. Each of the
// FETCH/EXEC/MEM/WB stages issues a single-cycle enable pulse. The FETCH,
// EXEC and MEM stages each wait, with a bounded timeout, for their done input.
// Retired instructions are counted.
module cpu_ctrl #(
  parameter int TMO_MAX = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] ir,
  input  logic        fetch_done,
  input  logic        exec_done,
  input  logic        mem_done,
  input  logic        stall,
  output logic        en_fetch,
  output logic        en_exec,
  output logic        en_mem,
  output logic        en_wb,
  output logic        alu_in_sel,
  output logic        mem_we,
  output logic        busy,
  output logic        halted,
  output logic [1:0]  err,
  output logic [15:0] instr_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_ADDI  = 4'h2;
  localparam logic [3:0] OP_LOAD  = 4'h3;
  localparam logic [3:0] OP_STORE = 4'h4;
  localparam logic [3:0] OP_HALT  = 4'hF;
  localparam logic [3:0] TMO_LIM  = 4'(TMO_MAX);

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  state_t      state_q;
  logic        pend_q;        // stage enable still owed for the current state
  logic [3:0]  tmo_q;
  logic [3:0]  op_q;
  logic        alu_in_sel_q;
  logic        mem_we_q;
  logic [1:0]  err_q;
  logic [15:0] instr_cnt_q;

  logic        done_d;
  logic [3:0]  tmo_d;
  logic        tmo_exp_d;
  logic [3:0]  dec_op_d;
  logic        unused_ir;

  assign dec_op_d  = ir[15:12];
  assign unused_ir = ^ir[11:0];

  // Select the done input relevant to the current wait state and detect timeout.
  always_comb begin
    done_d = 1'b0;
    case (state_q)
      S_FETCH: done_d = fetch_done;
      S_EXEC:  done_d = exec_done;
      S_MEM:   done_d = mem_done;
      default: done_d = 1'b0;
    endcase
    tmo_d     = tmo_q + 4'd1;
    // done in the same cycle the counter reaches the limit takes priority
    tmo_exp_d = !done_d && (tmo_d == TMO_LIM);
  end

  // Main sequencer; stall freezes every register, and pending pulses wait for it to drop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pend_q       <= 1'b0;
      tmo_q        <= 4'd0;
      op_q         <= OP_NOP;
      alu_in_sel_q <= 1'b0;
      mem_we_q     <= 1'b0;
      err_q        <= ERR_NONE;
      instr_cnt_q  <= 16'd0;
    end else if (!stall) begin
      pend_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_FETCH;
            pend_q  <= 1'b1;
            tmo_q   <= 4'd0;
          end
        end
        S_FETCH: begin
          if (fetch_done) begin
            state_q <= S_DECODE;
          end else if (tmo_exp_d) begin
            state_q <= S_HALT;
            err_q   <= ERR_TIMEOUT;
          end else begin
            tmo_q <= tmo_d;
          end
        end
        S_DECODE: begin
          op_q         <= dec_op_d;
          alu_in_sel_q <= (dec_op_d == OP_ADD);
          mem_we_q     <= (dec_op_d == OP_STORE);
          tmo_q        <= 4'd0;
          case (dec_op_d)
            OP_NOP: begin
              state_q     <= S_FETCH;
              pend_q      <= 1'b1;
              instr_cnt_q <= instr_cnt_q + 16'd1;
            end
            OP_ADD, OP_ADDI, OP_LOAD, OP_STORE: begin
              state_q <= S_EXEC;
              pend_q  <= 1'b1;
            end
            OP_HALT: begin
              state_q     <= S_HALT;
              instr_cnt_q <= instr_cnt_q + 16'd1;
            end
            default: begin
              state_q <= S_HALT;
              err_q   <= ERR_ILLEGAL;
            end
          endcase
        end
        S_EXEC: begin
          if (exec_done) begin
            state_q <= (op_q == OP_LOAD || op_q == OP_STORE) ? S_MEM : S_WB;
            pend_q  <= 1'b1;
            tmo_q   <= 4'd0;
          end else if (tmo_exp_d) begin
            state_q <= S_HALT;
            err_q   <= ERR_TIMEOUT;
          end else begin
            tmo_q <= tmo_d;
          end
        end
        S_MEM: begin
          if (mem_done) begin
            pend_q <= 1'b1;
            tmo_q  <= 4'd0;
            if (op_q == OP_LOAD) begin
              state_q <= S_WB;
            end else begin
              state_q     <= S_FETCH;
              instr_cnt_q <= instr_cnt_q + 16'd1;
            end
          end else if (tmo_exp_d) begin
            state_q <= S_HALT;
            err_q   <= ERR_TIMEOUT;
          end else begin
            tmo_q <= tmo_d;
          end
        end
        S_WB: begin
          state_q     <= S_FETCH;
          pend_q      <= 1'b1;
          tmo_q       <= 4'd0;
          instr_cnt_q <= instr_cnt_q + 16'd1;
        end
        default: begin
          // HALT: terminal until reset
          state_q <= S_HALT;
        end
      endcase
    end
  end

  // A pulse is visible only in its own state and only while not stalled.
  assign en_fetch   = pend_q && !stall && (state_q == S_FETCH);
  assign en_exec    = pend_q && !stall && (state_q == S_EXEC);
  assign en_mem     = pend_q && !stall && (state_q == S_MEM);
  assign en_wb      = pend_q && !stall && (state_q == S_WB);
  assign alu_in_sel = alu_in_sel_q;
  assign mem_we     = mem_we_q;
  assign busy       = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted     = (state_q == S_HALT);
  assign err        = err_q;
  assign instr_cnt  = instr_cnt_q;

endmodule

// File: tb/tb_cpu_ctrl.sv
// Directed bench for cpu_ctrl: a scoreboard queue holds the expected enable
// pulses (with alu_in_sel / mem_we qualifiers), and a negedge monitor pops
// and compares them; the main sequence checks state-level outputs.
module tb_cpu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] ir;
  logic        fetch_done;
  logic        exec_done;
  logic        mem_done;
  logic        stall;
  logic        en_fetch;
  logic        en_exec;
  logic        en_mem;
  logic        en_wb;
  logic        alu_in_sel;
  logic        mem_we;
  logic        busy;
  logic        halted;
  logic [1:0]  err;
  logic [15:0] instr_cnt;

  int n_vec = 0;
  int n_bad = 0;

  localparam logic [1:0] K_FETCH = 2'd0;
  localparam logic [1:0] K_EXEC  = 2'd1;
  localparam logic [1:0] K_MEM   = 2'd2;
  localparam logic [1:0] K_WB    = 2'd3;

  typedef struct packed {
    logic [1:0] kind;
    logic       aux;   // alu_in_sel for EXEC, mem_we for MEM
  } ev_t;

  ev_t exp_q[$];

  cpu_ctrl #(.TMO_MAX(15)) dut (
    .clk(clk), .rst(rst), .start(start), .ir(ir),
    .fetch_done(fetch_done), .exec_done(exec_done), .mem_done(mem_done),
    .stall(stall),
    .en_fetch(en_fetch), .en_exec(en_exec), .en_mem(en_mem), .en_wb(en_wb),
    .alu_in_sel(alu_in_sel), .mem_we(mem_we), .busy(busy), .halted(halted),
    .err(err), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_ev(input logic [1:0] kind, input logic aux);
    ev_t e;
    e.kind = kind;
    e.aux  = aux;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // From FETCH: present the instruction with fetch_done, land in DECODE.
  task automatic fetch_instr(input logic [15:0] v);
    ir         = v;
    fetch_done = 1'b1;
    step(1);
    fetch_done = 1'b0;
  endtask

  // Pulse monitor: every enable must match the head of the scoreboard.
  always @(negedge clk) begin
    logic [3:0] en_v;
    ev_t        e;
    en_v = {en_wb, en_mem, en_exec, en_fetch};
    if (en_v != 4'b0) begin
      check("pulse_onehot", $countones(en_v), 1);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {28'd0, en_v}, 0);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind", {28'd0, en_v}, {28'd0, 4'b0001 << e.kind});
        if (e.kind == K_EXEC) check("pulse_alu_in_sel", alu_in_sel, e.aux);
        if (e.kind == K_MEM)  check("pulse_mem_we", mem_we, e.aux);
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; ir = 16'h0; stall = 1'b0;
    fetch_done = 1'b0; exec_done = 1'b0; mem_done = 1'b0;
    step(2);
    check("rst_flags", {en_fetch, en_exec, en_mem, en_wb, alu_in_sel, mem_we, busy, halted}, 0);
    check("rst_err", err, 0);
    check("rst_cnt", instr_cnt, 0);
    rst = 1'b0;
    step(2);
    check("idle_busy", busy, 0);

    // ADDI 0x2005, fetch_done in the second FETCH cycle, exec_done one cycle after en_exec
    push_ev(K_FETCH, 1'b0);
    start = 1'b1;
    step(1);
    start = 1'b0;
    check("fetch_busy", busy, 1);
    step(1);
    fetch_instr(16'h2005);
    push_ev(K_EXEC, 1'b0);
    step(1);
    exec_done = 1'b1;
    push_ev(K_WB, 1'b0);
    step(1);
    exec_done = 1'b0;
    check("addi_wb_en", en_wb, 1);
    check("addi_alu_sel", alu_in_sel, 0);
    push_ev(K_FETCH, 1'b0);
    step(1);
    check("addi_cnt", instr_cnt, 1);
    check("addi_refetch", en_fetch, 1);

    // LOAD, mem_done three cycles after en_mem
    fetch_instr(16'h3012);
    push_ev(K_EXEC, 1'b0);
    step(1);
    exec_done = 1'b1;
    push_ev(K_MEM, 1'b0);
    step(1);
    exec_done = 1'b0;
    step(3);
    mem_done = 1'b1;
    push_ev(K_WB, 1'b0);
    step(1);
    mem_done = 1'b0;
    push_ev(K_FETCH, 1'b0);
    step(1);
    check("load_cnt", instr_cnt, 2);

    // STORE: mem_we high, no write-back
    fetch_instr(16'h4034);
    push_ev(K_EXEC, 1'b0);
    step(1);
    exec_done = 1'b1;
    push_ev(K_MEM, 1'b1);
    step(1);
    exec_done = 1'b0;
    check("store_mem_we", mem_we, 1);
    step(3);
    mem_done = 1'b1;
    push_ev(K_FETCH, 1'b0);
    step(1);
    mem_done = 1'b0;
    check("store_cnt", instr_cnt, 3);

    // ADD with exec_done in the 15th EXEC cycle: done beats the timeout
    fetch_instr(16'h1000);
    push_ev(K_EXEC, 1'b1);
    step(1);
    step(14);
    check("add_wait_busy", busy, 1);
    exec_done = 1'b1;
    push_ev(K_WB, 1'b0);
    step(1);
    exec_done = 1'b0;
    check("add_coinc_err", err, 0);
    check("add_coinc_halt", halted, 0);
    push_ev(K_FETCH, 1'b0);
    step(1);
    check("add_cnt", instr_cnt, 4);

    // ADDI with 5 stalled cycles on EXEC entry, then exec_done never arrives
    fetch_instr(16'h2001);
    step(1);
    stall = 1'b1;
    #1;
    check("stall_no_exec_0", en_exec, 0);
    for (int i = 1; i < 5; i++) begin
      step(1);
      check("stall_no_exec", en_exec, 0);
    end
    push_ev(K_EXEC, 1'b0);
    stall = 1'b0;
    #1;
    check("unstall_exec", en_exec, 1);
    step(14);
    check("tmo_not_yet", halted, 0);
    step(1);
    check("tmo_halted", halted, 1);
    check("tmo_err", err, 2);
    check("tmo_busy", busy, 0);
    check("tmo_cnt", instr_cnt, 4);
    start = 1'b1;
    step(2);
    start = 1'b0;
    check("halt_ignores_start", {halted, busy}, 2'b10);

    // Asynchronous reset out of HALT
    rst = 1'b1;
    #1;
    check("async_rst_halt", {halted, err}, 0);
    step(1);
    rst = 1'b0;

    // Illegal opcode
    push_ev(K_FETCH, 1'b0);
    start = 1'b1;
    step(1);
    start = 1'b0;
    fetch_instr(16'h7000);
    step(1);
    check("illegal_halt", halted, 1);
    check("illegal_err", err, 1);
    check("illegal_cnt", instr_cnt, 0);
    rst = 1'b1;
    step(1);
    rst = 1'b0;

    // HALT opcode retires
    push_ev(K_FETCH, 1'b0);
    start = 1'b1;
    step(1);
    start = 1'b0;
    fetch_instr(16'hF000);
    step(1);
    check("halt_op_halted", halted, 1);
    check("halt_op_err", err, 0);
    check("halt_op_cnt", instr_cnt, 1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;

    // NOP then LOAD aborted by reset in MEM
    push_ev(K_FETCH, 1'b0);
    start = 1'b1;
    step(1);
    start = 1'b0;
    fetch_instr(16'h0000);
    push_ev(K_FETCH, 1'b0);
    step(1);
    check("nop_cnt", instr_cnt, 1);
    fetch_instr(16'h3000);
    push_ev(K_EXEC, 1'b0);
    step(1);
    exec_done = 1'b1;
    push_ev(K_MEM, 1'b0);
    step(1);
    exec_done = 1'b0;
    step(1);
    rst = 1'b1;
    #1;
    check("mem_rst_flags", {en_fetch, en_exec, en_mem, en_wb, alu_in_sel, mem_we, busy, halted}, 0);
    check("mem_rst_cnt", instr_cnt, 0);
    step(1);
    rst = 1'b0;
    mem_done = 1'b1;
    step(3);
    mem_done = 1'b0;
    check("post_rst_idle", busy, 0);

    check("sb_drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
